// File: rtl/axis_slave_capture.sv
// ---------------------------------------------------------------------------
// axis_slave_capture
//
// Captures one AXI-Stream frame into a small register buffer. The frame is
// then held for a consumer, which reads it at random through rd_index and
// releases it with frame_ack. Beats beyond the buffer depth are accepted
// and thrown away, and the truncation is flagged through overflow.
//
// Ports
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   s_axis_data  : beat payload (WIDTH bits)
//   s_axis_valid : upstream beat valid
//   s_axis_last  : final beat of a frame
//   s_axis_ready : beat acceptance (low only while a frame is held)
//   frame_ack    : consumer pulse releasing the held frame
//   rd_index     : buffer read address
//   rd_data      : registered buffer word at rd_index (1-cycle latency)
//   frame_done   : a complete frame is held
//   frame_len    : number of stored beats in the held frame
//   overflow     : held frame was longer than MSG_LEN and was truncated
// ---------------------------------------------------------------------------
module axis_slave_capture #(
    parameter int WIDTH   = 8,
    parameter int MSG_LEN = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             s_axis_data,
    input  logic                         s_axis_valid,
    input  logic                         s_axis_last,
    output logic                         s_axis_ready,
    input  logic                         frame_ack,
    input  logic [$clog2(MSG_LEN)-1:0]   rd_index,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         frame_done,
    output logic [$clog2(MSG_LEN):0]     frame_len,
    output logic                         overflow
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        RECV = 2'd0,
        DROP = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e                        state_q, state_d;
    logic [AW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]                 frame_len_q, frame_len_d;
    logic                          frame_done_q, frame_done_d;
    logic                          overflow_q, overflow_d;
    logic [MSG_LEN-1:0][WIDTH-1:0] mem_q;
    logic [WIDTH-1:0]              rd_data_q;
    logic                          wr_en;
    logic                          hs;

    // Ready comes straight from the state register so it never depends
    // combinationally on valid.
    assign s_axis_ready = (state_q != HOLD);
    assign hs           = s_axis_valid && s_axis_ready;

    // ------------------------------------------------------------------
    // State register and frame status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RECV;
            wr_ptr_q     <= '0;
            frame_len_q  <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            frame_len_q  <= frame_len_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        frame_len_d  = frame_len_q;
        frame_done_d = frame_done_q;
        overflow_d   = overflow_q;
        wr_en        = 1'b0;

        case (state_q)
            RECV: begin
                if (hs) begin
                    wr_en    = 1'b1;
                    // When the last slot fills, the pointer wraps to 0. That
                    // is harmless: DROP never writes, and ack clears it.
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (s_axis_last) begin
                        state_d      = HOLD;
                        frame_len_d  = {1'b0, wr_ptr_q} + LW'(1);
                        frame_done_d = 1'b1;
                    end else if (wr_ptr_q == AW'(MSG_LEN - 1)) begin
                        overflow_d = 1'b1;
                        state_d    = DROP;
                    end
                end
            end

            DROP: begin
                // Surplus beats are accepted but not stored.
                if (hs && s_axis_last) begin
                    state_d      = HOLD;
                    frame_len_d  = LW'(MSG_LEN);
                    frame_done_d = 1'b1;
                end
            end

            HOLD: begin
                if (frame_ack) begin
                    state_d      = RECV;
                    wr_ptr_d     = '0;
                    frame_len_d  = '0;
                    frame_done_d = 1'b0;
                    overflow_d   = 1'b0;
                end
            end

            default: begin
                state_d = RECV;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Capture buffer and registered read port. The read samples mem_q
    // before the same-edge write lands, so a read and a write to the
    // same address return the old word.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q     <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= s_axis_data;
            end
            rd_data_q <= mem_q[rd_index];
        end
    end

    assign rd_data    = rd_data_q;
    assign frame_done = frame_done_q;
    assign frame_len  = frame_len_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/axis_slave_capture.md
AXIS_SLAVE_CAPTURE -- requirements
Module: axis_slave_capture

Interface
REQ-001 Parameter WIDTH, default 8, is the data beat width in bits.
REQ-002 Parameter MSG_LEN, default 8, is the capture buffer depth in beats (power of two, >= 2).
REQ-003 clk  input  1  is the single clock; all logic is rising-edge.
REQ-004 rst_n  input  1  is the asynchronous, active-low reset.
REQ-005 s_axis_data  input  WIDTH  is the AXI-Stream beat payload.
REQ-006 s_axis_valid  input  1  is the upstream beat-valid signal.
REQ-007 s_axis_last  input  1  marks the final beat of a frame.
REQ-008 s_axis_ready  output  1  is the beat-acceptance signal.
REQ-009 frame_ack  input  1  is the consumer pulse releasing a held frame.
REQ-010 rd_index  input  $clog2(MSG_LEN)  is the buffer read address.
REQ-011 rd_data  output  WIDTH  is the registered buffer word at rd_index.
REQ-012 frame_done  output  1  indicates that a complete frame is held.
REQ-013 frame_len  output  $clog2(MSG_LEN)+1  is the number of stored beats in the held frame.
REQ-014 overflow  output  1  indicates that the held frame exceeded MSG_LEN and was truncated.

Function
REQ-015 The FSM SHALL use three states: RECV (reset state), DROP and HOLD.
REQ-016 s_axis_ready SHALL be 1 in RECV and DROP and 0 in HOLD, decoded only from the state register.
REQ-017 A handshake SHALL be s_axis_valid && s_axis_ready at a rising edge; no other condition accepts a beat.
REQ-018 In RECV, a handshake SHALL write s_axis_data to mem[wr_ptr] and increment wr_ptr.
REQ-019 A RECV handshake with s_axis_last=1 SHALL go to HOLD, set frame_len=wr_ptr+1 and frame_done=1 at the next edge.
REQ-020 A RECV handshake at wr_ptr==MSG_LEN-1 with s_axis_last=0 SHALL store the beat, set overflow=1 and go to DROP.
REQ-021 In DROP, each handshake SHALL be discarded with memory unchanged; a handshake with s_axis_last=1 SHALL go to HOLD with frame_len=MSG_LEN and frame_done=1.
REQ-022 A single-beat frame (s_axis_last=1 on the first beat) SHALL give frame_len=1.
REQ-023 A frame of exactly MSG_LEN beats ending with s_axis_last SHALL give frame_len=MSG_LEN and overflow=0.
REQ-024 In HOLD, frame_ack=1 SHALL clear frame_done, overflow, frame_len and wr_ptr, and return to RECV at the next edge.
REQ-025 frame_ack SHALL be ignored in RECV and DROP.
REQ-026 s_axis_valid with no handshake in HOLD SHALL leave memory and outputs unchanged, and the beat SHALL remain pending upstream.
REQ-027 rd_data SHALL be updated every cycle to mem[rd_index], giving one-cycle read latency in all states.
REQ-028 A read and a write to the same address in the same cycle SHALL return the old memory content.
REQ-029 The minimum cycle from the last-beat handshake to the next accepted beat SHALL be 2 cycles: HOLD, then ack, then RECV.

Reset
REQ-030 rst_n=0 SHALL asynchronously force the state to RECV, wr_ptr=0, all mem entries=0, rd_data=0, frame_done=0, frame_len=0 and overflow=0.
REQ-031 s_axis_ready SHALL be 1 while and immediately after reset, because the state is RECV.
REQ-032 Reset asserted mid-frame or in HOLD SHALL discard the partial or held frame, with no frame_done pulse on release.
REQ-033 Release of rst_n SHALL be synchronous to clk, with the first beat accepted on the first edge after release.

Verification
REQ-034 Send 3 beats 0x48,0x45,0x4C with last on 0x4C -> frame_done=1, frame_len=3, overflow=0; rd_index 0..2 returns 0x48,0x45,0x4C one cycle after each address.
REQ-035 Send 10 beats 0x00..0x09 (MSG_LEN=8) with last on 0x09 -> overflow=1, frame_len=8, mem holds 0x00..0x07, and ready stays 1 through the dropped beats.
REQ-036 Hold valid=1 with 0xAA while in HOLD for 5 cycles, then pulse frame_ack -> no acceptance during HOLD; 0xAA is stored at index 0 of the next frame, one cycle after ack.
REQ-037 Single beat 0x5A with last=1 -> frame_len=1; a frame_ack pulse in RECV before it has no effect.
REQ-038 Assert rst_n=0 after 4 of 6 beats -> all outputs 0 and ready=1; a following 2-beat frame gives frame_len=2.
REQ-039 Send a random valid-toggling 8-beat frame ending in last -> frame_len=8, overflow=0, and contents match the scoreboard.
